cdb_result_queue: RTL and testbench
===================================

// Module: cdb_result_queue
// PURPOSE
//   Transmit end of the common data bus (CDB). Buffers completed results (tag + data) from one
//   execution unit and presents them in FIFO order as a CDB producer. Drives request/tag/data
//   toward the CDB priority arbiter and pops an entry when the arbiter grants it. Decouples unit
//   completion from bus availability, so the execution unit never stalls on a lost arbitration.
// PARAMETERS
//   DATA_WIDTH     4   bitwidth of a result data word
//   CDB_TAG_WIDTH  4   bitwidth of a CDB tag; CDB_TAG_WIDTH <= DATA_WIDTH
//   DEPTH          4   number of queue entries; power of two, >= 2
// PORTS
//   clk               in   1                         single clock, all state on rising edge
//   rst               in   1                         asynchronous, active-high reset
//   flush             in   1                         synchronous clear of all entries
//   in_valid          in   1                         execution unit presents a result
//   in_tag            in   CDB_TAG_WIDTH             result tag
//   in_data           in   DATA_WIDTH                result value
//   in_ready          out  1                         queue accepts a result this cycle
//   cdb_out_request   out  1                         request CDB ownership (to arbiter req bit)
//   cdb_out_tag       out  CDB_TAG_WIDTH             head-entry tag
//   cdb_out_data      out  DATA_WIDTH                head-entry data
//   cdb_out_accepted  in   1                         arbiter grant, combinational in same cycle
//   occupancy         out  $clog2(DEPTH+1)           current entry count
// BEHAVIOUR
//   - Reset (async assert, sync release): rd_ptr = wr_ptr = count = 0. cdb_out_request = 0,
//     cdb_out_tag = 0, cdb_out_data = 0, occupancy = 0, in_ready = 1. Storage is not reset.
//   - Push: when in_valid && in_ready at a rising edge, write {tag, data} at wr_ptr and advance
//     wr_ptr. in_ready = (count != DEPTH). It does not depend on cdb_out_accepted, so there is no
//     combinational path from the grant to the input side.
//   - Pop: when cdb_out_request && cdb_out_accepted at a rising edge, advance rd_ptr.
//     cdb_out_accepted with request low is ignored.
//   - Outputs: cdb_out_request = (count != 0). cdb_out_tag/cdb_out_data show the head entry
//     when count != 0 and are forced to 0 when empty, so the bus never carries stale values.
//     Head values hold stable while request is high and no grant occurs.
//   - Latency: a push at edge N gives request high after edge N (first cycle N+1). There is no
//     in->out bypass. A granted entry is on the bus for exactly the one granted cycle.
//   - Simultaneous push and pop (not full): both happen and count is unchanged. When full, the
//     push is refused even if a pop occurs in the same cycle.
//   - Pointers: log2(DEPTH) bits and wrap naturally. count is tracked separately, with width
//     $clog2(DEPTH+1), so full and empty are unambiguous.
//   - flush: at the edge, pointers and count return to 0. flush overrides a simultaneous push
//     and pop: the pushed entry is dropped and the granted entry is treated as consumed.
//   - Reset asserted mid-transfer: request drops immediately (async), all entries are lost,
//     and no partial state survives.
//   - Ordering: strict FIFO. No tag checking or reordering inside this block.
// STRUCTURE
//   - Shared include (cdb_defs.vh): default DATA_WIDTH and CDB_TAG_WIDTH, and the CDB producer
//     port bundle ordering. This keeps the arbiter, producers and consumers consistent.
//   - No sub-module. Storage is an inline DEPTH x (CDB_TAG_WIDTH+DATA_WIDTH) register array
//     with rd_ptr, wr_ptr and count. The block is instantiated once per CDB producer; its
//     request bit drives that producer's arbiter priority slot.
// TESTING
//   1. Reset then idle: rst pulse -> request=0, tag=0, data=0, occupancy=0, in_ready=1.
//   2. Single result: push tag=3, data=9 with accepted held 1 -> request high one cycle later
//      with tag=3, data=9; popped at the next edge; occupancy returns to 0.
//   3. Backpressure: hold accepted=0 and push 4 results (tags 1..4) -> occupancy=4, in_ready=0;
//      a 5th push is ignored. Grant 4 cycles -> tags appear in order 1,2,3,4, then request=0.
//   4. Simultaneous push/pop at occupancy=2 -> occupancy stays 2 and order is preserved. At
//      occupancy=4 with a grant, the push is refused and occupancy becomes 3.
//   5. Grant without request (empty queue, accepted=1) -> no pointer movement, outputs stay 0.
//   6. flush with 3 entries plus a concurrent push, and async rst mid-stream -> occupancy=0,
//      request=0 after the edge (immediately for rst), and the next push starts cleanly.

Source files
------------

// File: rtl/cdb_result_queue_pkg.sv
// Shared defaults and queue-operation encoding for the CDB result queue.
package cdb_result_queue_pkg;

    localparam int unsigned CDB_DATA_WIDTH_DEF = 4;
    localparam int unsigned CDB_TAG_WIDTH_DEF  = 4;
    localparam int unsigned CDB_DEPTH_DEF      = 4;

    typedef enum logic [1:0] {
        Q_IDLE     = 2'b00,
        Q_PUSH     = 2'b01,
        Q_POP      = 2'b10,
        Q_PUSH_POP = 2'b11
    } q_op_e;

    function automatic q_op_e q_op(input logic push, input logic pop);
        case ({pop, push})
            2'b01:   return Q_PUSH;
            2'b10:   return Q_POP;
            2'b11:   return Q_PUSH_POP;
            default: return Q_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cdb_result_queue_if.sv
// Execution-unit input and CDB producer output bundle of one result queue.
interface cdb_result_queue_if
    import cdb_result_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = CDB_DATA_WIDTH_DEF,
    parameter int unsigned CDB_TAG_WIDTH = CDB_TAG_WIDTH_DEF
);
    logic                     in_valid;
    logic [CDB_TAG_WIDTH-1:0] in_tag;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_ready;
    logic                     cdb_out_request;
    logic [CDB_TAG_WIDTH-1:0] cdb_out_tag;
    logic [DATA_WIDTH-1:0]    cdb_out_data;
    logic                     cdb_out_accepted;

    // master: execution unit plus arbiter side; slave: the queue itself
    modport master (
        output in_valid, in_tag, in_data, cdb_out_accepted,
        input  in_ready, cdb_out_request, cdb_out_tag, cdb_out_data
    );

    modport slave (
        input  in_valid, in_tag, in_data, cdb_out_accepted,
        output in_ready, cdb_out_request, cdb_out_tag, cdb_out_data
    );
endinterface

// File: rtl/cdb_result_queue.sv
// FIFO of completed results feeding one CDB arbiter slot; head is zeroed when empty.
module cdb_result_queue
    import cdb_result_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = CDB_DATA_WIDTH_DEF,
    parameter int unsigned CDB_TAG_WIDTH = CDB_TAG_WIDTH_DEF,
    parameter int unsigned DEPTH         = CDB_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    cdb_result_queue_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = CDB_TAG_WIDTH + DATA_WIDTH;

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               push, pop;
    q_op_e              op;

    // in_ready depends only on count, keeping the grant off the input path
    assign bus.in_ready        = (count_q != CNT_W'(DEPTH));
    assign bus.cdb_out_request = (count_q != '0);
    assign push                = bus.in_valid && bus.in_ready;
    assign pop                 = bus.cdb_out_request && bus.cdb_out_accepted;
    assign op                  = q_op(push, pop);
    assign occupancy           = count_q;

    assign {bus.cdb_out_tag, bus.cdb_out_data} =
        bus.cdb_out_request ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        case (op)
            Q_PUSH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
            Q_POP: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
            Q_PUSH_POP: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: ;
        endcase
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= {bus.in_tag, bus.in_data};
        end
    end

endmodule

// File: tb/tb_cdb_result_queue.sv
// Scoreboard bench for cdb_result_queue: expected entries queued on push, compared at the head.
module tb_cdb_result_queue;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] occupancy;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb [$];

    cdb_result_queue_if #(.DATA_WIDTH(4), .CDB_TAG_WIDTH(4)) bus ();

    cdb_result_queue #(.DATA_WIDTH(4), .CDB_TAG_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compares outputs against the model mid-cycle, then applies the edge to the model.
    task automatic tick();
        logic [7:0] head;
        logic       push_ok, pop_ok;
        int         n;
        @(negedge clk);
        n    = sb.size();
        head = (n != 0) ? sb[0] : 8'h00;
        chk("occupancy", 32'(occupancy), 32'(n));
        chk("in_ready", 32'(bus.in_ready), 32'(n != DEPTH));
        chk("request", 32'(bus.cdb_out_request), 32'(n != 0));
        chk("tag", 32'(bus.cdb_out_tag), 32'(head[7:4]));
        chk("data", 32'(bus.cdb_out_data), 32'(head[3:0]));
        push_ok = bus.in_valid && (n != DEPTH);
        pop_ok  = (n != 0) && bus.cdb_out_accepted;
        if (flush) begin
            sb.delete();
        end else begin
            if (pop_ok) void'(sb.pop_front());
            if (push_ok) sb.push_back({bus.in_tag, bus.in_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] t, input logic [3:0] d);
        bus.in_valid = 1'b1;
        bus.in_tag   = t;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        flush                = 1'b0;
        bus.in_valid         = 1'b0;
        bus.in_tag           = '0;
        bus.in_data          = '0;
        bus.cdb_out_accepted = 1'b0;

        // reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_request", 32'(bus.cdb_out_request), 32'd0);
        chk("rst_tag", 32'(bus.cdb_out_tag), 32'd0);
        chk("rst_data", 32'(bus.cdb_out_data), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tick();

        // single result with grant held high
        bus.cdb_out_accepted = 1'b1;
        push(4'd3, 4'd9);
        tick();
        tick();

        // backpressure: fill, fifth push refused, then drain in order
        bus.cdb_out_accepted = 1'b0;
        for (int i = 1; i <= 5; i++) push(4'(i), 4'(i * 3));
        chk("full_occupancy", 32'(occupancy), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.cdb_out_accepted = 1'b1;
        repeat (5) tick();

        // simultaneous push/pop at occupancy 2, then at full
        bus.cdb_out_accepted = 1'b0;
        push(4'd5, 4'd1);
        push(4'd6, 4'd2);
        bus.cdb_out_accepted = 1'b1;
        push(4'd7, 4'd3);
        chk("pushpop_occupancy", 32'(occupancy), 32'd2);
        bus.cdb_out_accepted = 1'b0;
        push(4'd8, 4'd4);
        push(4'd9, 4'd5);
        chk("full2_occupancy", 32'(occupancy), 32'd4);
        bus.cdb_out_accepted = 1'b1;
        push(4'd10, 4'd6);
        chk("full_pop_occupancy", 32'(occupancy), 32'd3);
        bus.cdb_out_accepted = 1'b1;
        repeat (4) tick();

        // grant without request
        repeat (3) tick();

        // flush with 3 entries plus concurrent push and grant
        bus.cdb_out_accepted = 1'b0;
        push(4'd1, 4'd15);
        push(4'd2, 4'd14);
        push(4'd3, 4'd13);
        flush                = 1'b1;
        bus.cdb_out_accepted = 1'b1;
        push(4'd4, 4'd12);
        flush                = 1'b0;
        chk("flush_occupancy", 32'(occupancy), 32'd0);
        chk("flush_request", 32'(bus.cdb_out_request), 32'd0);
        bus.cdb_out_accepted = 1'b0;
        push(4'd11, 4'd7);
        push(4'd12, 4'd8);
        tick();

        // async reset mid-stream
        rst = 1'b1;
        #1;
        chk("arst_request", 32'(bus.cdb_out_request), 32'd0);
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(4'd13, 4'd6);
        bus.cdb_out_accepted = 1'b1;
        repeat (2) tick();

        // random traffic
        for (int c = 0; c < 300; c++) begin
            bus.in_valid         = 1'($urandom_range(0, 1));
            bus.in_tag           = 4'($urandom);
            bus.in_data          = 4'($urandom);
            bus.cdb_out_accepted = ($urandom_range(0, 2) == 0);
            flush                = ($urandom_range(0, 40) == 0);
            tick();
        end
        bus.in_valid         = 1'b0;
        flush                = 1'b0;
        bus.cdb_out_accepted = 1'b1;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
